id_wb_arbiter: RTL and testbench

- Controller that shares the register file's single write port between two write-back requesters: port 0 (ALU path) and port 1 (load/long-latency path).
- Keeps a per-register pending scoreboard and stalls issue on RAW/WAW hazards against in-flight writes.
- Sits between decode/issue and id_reg_file; drives id_reg_file's reg_write/data_write inputs.

---
 rtl/id_wb_arbiter_if.sv | 40 ++++
 rtl/id_wb_arbiter.sv | 76 +++++++
 tb/tb_id_wb_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_wb_arbiter_if.sv
// rtl/id_wb_arbiter_if.sv - issue, write-back and register-file write signals of id_wb_arbiter
// master: decode/issue plus both write-back requesters; slave: the arbiter.
interface id_wb_arbiter_if #(
  parameter int REG_NUM = 32,
  parameter int REG_W   = 5,
  parameter int DATA_W  = 32
);
  logic               iss_valid;
  logic [REG_W-1:0]   iss_rs1;
  logic [REG_W-1:0]   iss_rs2;
  logic [REG_W-1:0]   iss_rd;
  logic               iss_stall;
  logic               wb0_valid;
  logic [REG_W-1:0]   wb0_rd;
  logic [DATA_W-1:0]  wb0_data;
  logic               wb0_ready;
  logic               wb1_valid;
  logic [REG_W-1:0]   wb1_rd;
  logic [DATA_W-1:0]  wb1_data;
  logic               wb1_ready;
  logic [REG_W-1:0]   reg_write;
  logic [DATA_W-1:0]  data_write;
  logic [REG_NUM-1:0] pending;

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd,
    output wb0_valid, wb0_rd, wb0_data,
    output wb1_valid, wb1_rd, wb1_data,
    input  iss_stall, wb0_ready, wb1_ready,
    input  reg_write, data_write, pending
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd,
    input  wb0_valid, wb0_rd, wb0_data,
    input  wb1_valid, wb1_rd, wb1_data,
    output iss_stall, wb0_ready, wb1_ready,
    output reg_write, data_write, pending
  );
endinterface

// File: rtl/id_wb_arbiter.sv
// rtl/id_wb_arbiter.sv - round-robin write-back arbiter with pending-register hazard scoreboard
// Define WB_BYPASS_EN to let a register being cleared by this cycle's grant stop stalling issue.
module id_wb_arbiter #(
  parameter int REG_NUM = 32,
  parameter int REG_W   = 5,
  parameter int DATA_W  = 32
) (
  input logic            clk,
  input logic            rst,
  id_wb_arbiter_if.slave bus
);

  logic [REG_NUM-1:0] pending_q, pending_d;
  logic [REG_W-1:0]   reg_write_q, reg_write_d;
  logic [DATA_W-1:0]  data_write_q, data_write_d;
  logic               prio1_q, prio1_d;  // port 1 wins the next contention

  logic               contend, grant0, grant1, grant_any, stall, accept;
  logic [REG_W-1:0]   grant_rd;
  logic [DATA_W-1:0]  grant_data;
  logic [REG_NUM-1:0] clr_mask, set_mask, hazard_vec;

  always_comb begin
    contend    = bus.wb0_valid & bus.wb1_valid;
    grant0     = bus.wb0_valid & (~bus.wb1_valid | ~prio1_q);
    grant1     = bus.wb1_valid & (~bus.wb0_valid | prio1_q);
    grant_any  = grant0 | grant1;
    grant_rd   = grant1 ? bus.wb1_rd   : bus.wb0_rd;
    grant_data = grant1 ? bus.wb1_data : bus.wb0_data;

    clr_mask = '0;
    if (grant_any) clr_mask[grant_rd] = 1'b1;

`ifdef WB_BYPASS_EN
    hazard_vec = pending_q & ~clr_mask;
`else
    hazard_vec = pending_q;
`endif
    stall  = bus.iss_valid &
             (hazard_vec[bus.iss_rs1] | hazard_vec[bus.iss_rs2] | hazard_vec[bus.iss_rd]);
    accept = bus.iss_valid & ~stall;

    set_mask = '0;
    if (accept) set_mask[bus.iss_rd] = 1'b1;

    // Set is OR-ed after the clear so a new issue keeps ownership on collision.
    pending_d    = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;

    prio1_d      = contend ? grant0 : prio1_q;
    reg_write_d  = grant_any ? grant_rd : '0;
    data_write_d = grant_any ? grant_data : data_write_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q    <= '0;
      reg_write_q  <= '0;
      data_write_q <= '0;
      prio1_q      <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      reg_write_q  <= reg_write_d;
      data_write_q <= data_write_d;
      prio1_q      <= prio1_d;
    end
  end

  assign bus.iss_stall  = stall;
  assign bus.wb0_ready  = grant0;
  assign bus.wb1_ready  = grant1;
  assign bus.reg_write  = reg_write_q;
  assign bus.data_write = data_write_q;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_id_wb_arbiter.sv
// tb/tb_id_wb_arbiter.sv - directed and randomized bench for id_wb_arbiter against a scoreboard model
module tb_id_wb_arbiter;
  localparam int REG_NUM = 32;
  localparam int REG_W   = 5;
  localparam int DATA_W  = 32;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_wb_arbiter_if #(.REG_NUM(REG_NUM), .REG_W(REG_W), .DATA_W(DATA_W)) bus ();
  id_wb_arbiter #(.REG_NUM(REG_NUM), .REG_W(REG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  bit          pend_m[REG_NUM];
  int          last_win;   // port that won the latest contention, -1 after reset
  int          last_g;     // port granted in the latest cycle, -1 for none
  int          exp_rw;
  logic [31:0] exp_dw;
  int          passed = 0;
  int          total  = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [REG_NUM-1:0] model_vec();
    logic [REG_NUM-1:0] v;
    for (int i = 0; i < REG_NUM; i++) v[i] = pend_m[i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < REG_NUM; i++) pend_m[i] = 1'b0;
    last_win = -1; last_g = -1; exp_rw = 0; exp_dw = '0;
  endfunction

  function automatic int model_grant();
    if (bus.wb0_valid && bus.wb1_valid) return (last_win == 0) ? 1 : 0;
    if (bus.wb0_valid) return 0;
    if (bus.wb1_valid) return 1;
    return -1;
  endfunction

  function automatic bit model_stall(int g);
    int r[3];
    int grd;
    bit busy;
    if (!bus.iss_valid) return 1'b0;
    r   = '{int'(bus.iss_rs1), int'(bus.iss_rs2), int'(bus.iss_rd)};
    grd = (g == 1) ? int'(bus.wb1_rd) : int'(bus.wb0_rd);
    for (int k = 0; k < 3; k++) begin
      busy = pend_m[r[k]];
      if (BYP && g >= 0 && r[k] == grd) busy = 1'b0;
      if (busy) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Inputs are driven at posedge+1; combinational outputs checked at posedge+4,
  // registered outputs at the following posedge+1.
  task automatic cycle();
    int g, rd;
    bit st;
    #3;
    g  = model_grant();
    st = model_stall(g);
    chk("iss_stall", bus.iss_stall, st);
    chk("wb0_ready", bus.wb0_ready, g == 0);
    chk("wb1_ready", bus.wb1_ready, g == 1);
    @(posedge clk);
    if (bus.wb0_valid && bus.wb1_valid) last_win = g;
    if (g >= 0) begin
      rd     = (g == 1) ? int'(bus.wb1_rd) : int'(bus.wb0_rd);
      exp_dw = (g == 1) ? bus.wb1_data : bus.wb0_data;
      exp_rw = rd;
      pend_m[rd] = 1'b0;
    end else begin
      exp_rw = 0;
    end
    if (bus.iss_valid && !st && bus.iss_rd != 0) pend_m[bus.iss_rd] = 1'b1;
    last_g = g;
    #1;
    chk("reg_write", bus.reg_write, exp_rw);
    chk("data_write", bus.data_write, exp_dw);
    chk("pending", bus.pending, model_vec());
  endtask

  task automatic iss(bit v, int rs1, int rs2, int rd);
    bus.iss_valid = v;
    bus.iss_rs1 = REG_W'(rs1); bus.iss_rs2 = REG_W'(rs2); bus.iss_rd = REG_W'(rd);
  endtask

  task automatic wb(int p, bit v, int rd, logic [31:0] d);
    if (p == 0) begin bus.wb0_valid = v; bus.wb0_rd = REG_W'(rd); bus.wb0_data = d; end
    else        begin bus.wb1_valid = v; bus.wb1_rd = REG_W'(rd); bus.wb1_data = d; end
  endtask

  initial begin
    model_reset();
    iss(0, 0, 0, 0);
    wb(0, 0, 0, '0);
    wb(1, 0, 0, '0);
    #2;
    chk("rst_pending", bus.pending, '0);
    chk("rst_reg_write", bus.reg_write, '0);
    chk("rst_data_write", bus.data_write, '0);
    chk("rst_stall", bus.iss_stall, 1'b0);
    chk("rst_ready0", bus.wb0_ready, 1'b0);
    #8 rst = 1'b1;
    @(posedge clk); #1;

    // Contention from reset: port 0 first, then alternation with port 1 first.
    wb(0, 1, 1, 32'd11); wb(1, 1, 2, 32'd22);
    cycle();
    chk("cont1_rw", bus.reg_write, 5'd1);
    chk("cont1_dw", bus.data_write, 32'd11);
    wb(0, 0, 0, '0);
    cycle();
    chk("cont2_rw", bus.reg_write, 5'd2);
    chk("cont2_dw", bus.data_write, 32'd22);
    wb(0, 1, 1, 32'd11); wb(1, 1, 2, 32'd22);
    cycle();
    chk("cont3_rw", bus.reg_write, 5'd2);
    wb(1, 0, 0, '0);
    cycle();
    chk("cont4_rw", bus.reg_write, 5'd1);
    wb(0, 0, 0, '0);

    // Single issue then write-back.
    iss(1, 0, 0, 5);
    cycle();
    chk("t1_pend5_set", bus.pending[5], 1'b1);
    iss(0, 0, 0, 0);
    wb(0, 1, 5, 32'h1234);
    cycle();
    chk("t1_rw", bus.reg_write, 5'd5);
    chk("t1_dw", bus.data_write, 32'h1234);
    chk("t1_pend5_clr", bus.pending[5], 1'b0);
    wb(0, 0, 0, '0);
    cycle();
    chk("t1_idle_rw", bus.reg_write, 5'd0);
    chk("t1_idle_dw", bus.data_write, 32'h1234);

    // RAW stall on pending[3].
    iss(1, 0, 0, 3);
    cycle();
    iss(1, 3, 0, 7);
    cycle();
    chk("raw_pend7_a", bus.pending[7], 1'b0);
    cycle();
    chk("raw_pend7_b", bus.pending[7], 1'b0);
    wb(1, 1, 3, 32'hCAFE);
    cycle();
    chk("raw_pend7_grant", bus.pending[7], BYP);
    wb(1, 0, 0, '0);
    if (!BYP) begin
      cycle();
      chk("raw_pend7_after", bus.pending[7], 1'b1);
    end
    iss(0, 0, 0, 0);
    wb(0, 1, 7, 32'h77);
    cycle();
    wb(0, 0, 0, '0);

    // x0 handling.
    iss(1, 0, 0, 0);
    cycle();
    chk("x0_pending", bus.pending, '0);
    iss(0, 0, 0, 0);
    wb(1, 1, 0, 32'hFFFF);
    cycle();
    chk("x0_rw", bus.reg_write, 5'd0);
    wb(1, 0, 0, '0);

    // Same-edge set and clear of register 4.
    iss(1, 0, 0, 4);
    cycle();
    wb(0, 1, 4, 32'h44);
    cycle();
    chk("coll_pend4", bus.pending[4], BYP);
    iss(0, 0, 0, 0);
    wb(0, 0, 0, '0);
    if (BYP) begin
      wb(0, 1, 4, 32'h45);
      cycle();
      wb(0, 0, 0, '0);
    end

    // Asynchronous reset mid-cycle.
    iss(1, 0, 0, 4);
    cycle();
    iss(1, 0, 0, 9);
    cycle();
    iss(0, 0, 0, 0);
    wb(1, 1, 4, 32'h99);
    cycle();
    chk("mid_pend_before", bus.pending[9], 1'b1);
    #3 rst = 1'b0;
    #1;
    model_reset();
    chk("mid_pending", bus.pending, '0);
    chk("mid_reg_write", bus.reg_write, '0);
    chk("mid_data_write", bus.data_write, '0);
    wb(1, 0, 0, '0);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic; requesters hold until granted.
    for (int n = 0; n < 400; n++) begin
      if (last_g == 0) bus.wb0_valid = 1'b0;
      if (last_g == 1) bus.wb1_valid = 1'b0;
      if (!bus.wb0_valid && $urandom_range(0, 1) == 1)
        wb(0, 1, $urandom_range(0, 7), $urandom);
      if (!bus.wb1_valid && $urandom_range(0, 1) == 1)
        wb(1, 1, $urandom_range(0, 7), $urandom);
      iss($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 7));
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
